mc_core_param: RTL and testbench

- Parametrised successor to the fixed 16-bit multicycle datapath: merges datapath and sequencer into one block.
- Data width and memory address width are generic.
- Memory access uses a req/ack handshake with arbitrary wait states, replacing the fixed one-cycle memory.
- Sits between the top-level controller and a shared instruction/data memory; exposes PC, flags and state for the bench.

---
 rtl/mc_pkg.sv | 39 +++
 rtl/mc_core_param_if.sv | 17 +
 rtl/mc_regfile.sv | 27 ++
 rtl/mc_core_param.sv | 176 +++++++++++++++++
 tb/tb_mc_core_param.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the parameterised multicycle core: opcodes, FSM
// state codes, instruction field positions and the flag word layout.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADC  = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI = 15, OP_LO = 12;
  localparam int D_HI  = 11, D_LO  = 9;
  localparam int M_HI  = 8,  M_LO  = 6;
  localparam int N_HI  = 5,  N_LO  = 3;
  localparam int IMM_HI = 7;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } psw_t;

endpackage

// File: rtl/mc_core_param_if.sv
// Memory bus between the core and the shared instruction/data memory.
interface mc_core_param_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/mc_regfile.sv
// 8 x DW register file: three combinational reads, one synchronous write.
module mc_regfile #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [2:0]    waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [2:0]    ra_i,
  input  logic [2:0]    rb_i,
  input  logic [2:0]    rd_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [DW-1:0] d_o
);
  logic [7:0][DW-1:0] regs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    regs_q <= '0;
    else if (we_i) regs_q[waddr_i] <= wdata_i;
  end

  assign a_o = regs_q[ra_i];
  assign b_o = regs_q[rb_i];
  assign d_o = regs_q[rd_i];
endmodule

// File: rtl/mc_core_param.sv
// Multicycle core: sequencer and datapath in one block, memory accesses
// through a req/ack handshake that tolerates any number of wait states.
module mc_core_param
  import mc_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            Rst_n,
  mc_core_param_if.master bus,
  output logic [AW-1:0]   pc,
  output logic [2:0]      psw,
  output logic            halted,
  output logic [2:0]      state
);
  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, d_q, d_d, res_q, res_d;
  psw_t          psw_q, psw_d;

  logic [DW-1:0] rf_a, rf_b, rf_d;
  logic          rf_we, req, we;
  logic [AW-1:0] addr;
  logic [3:0]    op;
  logic [DW:0]   sum;
  logic [DW-1:0] alu_y, imm_dw;
  logic [AW-1:0] imm_aw;
  logic          alu_c;
  logic signed [7:0] imm_s;

  assign op     = ir_q[OP_HI:OP_LO];
  assign imm_s  = ir_q[IMM_HI:0];
  assign imm_dw = DW'(imm_s);
  assign imm_aw = AW'(imm_s);

  mc_regfile #(.DW(DW)) u_rf (
    .clk(clk), .rst_n(Rst_n),
    .we_i(rf_we), .waddr_i(ir_q[D_HI:D_LO]), .wdata_i(res_q),
    .ra_i(ir_q[M_HI:M_LO]), .rb_i(ir_q[N_HI:N_LO]), .rd_i(ir_q[D_HI:D_LO]),
    .a_o(rf_a), .b_o(rf_b), .d_o(rf_d)
  );

  always_comb begin
    sum   = '0;
    alu_y = '0;
    alu_c = 1'b0;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        alu_y = sum[DW-1:0];
        alu_c = sum[DW];
      end
      OP_ADC: begin
        sum   = {1'b0, a_q} + {1'b0, b_q} + (DW+1)'(psw_q.c);
        alu_y = sum[DW-1:0];
        alu_c = sum[DW];
      end
      OP_SUB: begin
        alu_y = a_q - b_q;
        alu_c = (a_q >= b_q);  // carry means no borrow
      end
      OP_AND: alu_y = a_q & b_q;
      OP_OR:  alu_y = a_q | b_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    res_d   = res_q;
    psw_d   = psw_q;
    req     = 1'b0;
    we      = 1'b0;
    addr    = pc_q;
    rf_we   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata[15:0];
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        d_d     = rf_d;
        state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADC: begin
            res_d   = alu_y;
            psw_d   = '{n: alu_y[DW-1], z: (alu_y == '0), c: alu_c};
            state_d = S_WB;
          end
          OP_LI: begin
            res_d   = imm_dw;
            state_d = S_WB;
          end
          OP_LD, OP_ST: state_d = S_MEM;
          OP_BZ:  if (psw_q.z) pc_d = pc_q + imm_aw;
          OP_JMP: pc_d = a_q[AW-1:0];
          OP_JAL: begin
            res_d   = DW'(pc_q);
            pc_d    = a_q[AW-1:0];
            state_d = S_WB;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        req  = 1'b1;
        addr = a_q[AW-1:0];
        we   = (op == OP_ST);
        if (bus.mem_ack) begin
          if (op == OP_LD) begin
            res_d   = bus.mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      res_q   <= '0;
      psw_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      res_q   <= res_d;
      psw_q   <= psw_d;
    end
  end

  // Reset state is FETCH, so the request is gated to drop during reset.
  assign bus.mem_req   = req & Rst_n;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = d_q;

  assign pc     = pc_q;
  assign psw    = psw_q;
  assign halted = (state_q == S_HALT);
  assign state  = state_q;
endmodule

// File: tb/tb_mc_core_param.sv
// Bench for mc_core_param: memory responder logs every completed access,
// checked against an expected access trace with per-access cycle deltas.
module tb_mc_core_param;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic Rst_n;
  always #5 clk = ~clk;

  mc_core_param_if #(.DW(16), .AW(8)) mif ();
  logic [7:0] pc;
  logic [2:0] psw, state;
  logic       halted;

  mc_core_param #(.DW(16), .AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .Rst_n(Rst_n), .bus(mif.master),
    .pc(pc), .psw(psw), .halted(halted), .state(state)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [2:0]  psw;
    int          cyc;  // observed: ack cycle; expected: delta from previous ack (0 = skip)
  } acc_t;

  acc_t        obs[$];
  acc_t        exp_q[$];
  acc_t        rsp_e;
  logic [15:0] mem [0:255];
  int          cyc = 0;
  bit          stall;
  int          wcnt = 0;
  int          passed = 0, total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Addresses 0x40..0x7F respond with three wait states.
  always @(negedge clk) begin
    mif.mem_ack = 1'b0;
    if (mif.mem_req === 1'b1 && !stall) begin
      if (wcnt >= ((mif.mem_addr >= 8'h40 && mif.mem_addr < 8'h80) ? 3 : 0)) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = mem[mif.mem_addr];
        rsp_e.we   = mif.mem_we;
        rsp_e.addr = mif.mem_addr;
        rsp_e.data = mif.mem_wdata;
        rsp_e.psw  = psw;
        rsp_e.cyc  = cyc;
        obs.push_back(rsp_e);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  function automatic logic [15:0] i3(input logic [3:0] op, input logic [2:0] d,
                                     input logic [2:0] m, input logic [2:0] n);
    return {op, d, m, n, 3'b000};
  endfunction

  function automatic logic [15:0] li(input logic [2:0] d, input logic [7:0] imm);
    return {4'h6, d, 1'b0, imm};
  endfunction

  task automatic ex(input logic we, input logic [7:0] a, input logic [15:0] d,
                    input logic [2:0] p, input int delta);
    acc_t e;
    e.we = we; e.addr = a; e.data = d; e.psw = p; e.cyc = delta;
    exp_q.push_back(e);
  endtask

  int oi = 0;

  task automatic wait_halt_and_compare(input string name);
    acc_t e, o;
    int   prev = 0;
    int   n = 0;
    for (int i = 0; i < 3000 && halted !== 1'b1; i++) @(posedge clk);
    #1;
    chk({name, "_halted"}, 32'(halted), 32'd1);
    chk({name, "_trace_len"}, 32'(obs.size() - oi), 32'(exp_q.size()));
    while (exp_q.size() > 0 && oi < obs.size()) begin
      e = exp_q.pop_front();
      o = obs[oi];
      oi++;
      chk($sformatf("%s_acc%0d_we_addr", name, n), 32'({o.we, o.addr}), 32'({e.we, e.addr}));
      if (e.we) begin
        chk($sformatf("%s_acc%0d_wdata", name, n), 32'(o.data), 32'(e.data));
        chk($sformatf("%s_acc%0d_psw", name, n), 32'(o.psw), 32'(e.psw));
      end
      if (e.cyc != 0)
        chk($sformatf("%s_acc%0d_delta", name, n), 32'(o.cyc - prev), 32'(e.cyc));
      prev = o.cyc;
      n++;
    end
    exp_q.delete();
    oi = obs.size();
  endtask

  initial begin
    int hreq;
    Rst_n = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    // Program A: ALU ops and flags, results stored to 0x30
    mem[8'h00] = li(6, 8'h30);       mem[8'h01] = li(1, 8'hFF);
    mem[8'h02] = li(2, 8'h01);       mem[8'h03] = i3(OP_ADD, 3, 1, 2);
    mem[8'h04] = i3(OP_ST, 3, 6, 0); mem[8'h05] = i3(OP_ADC, 4, 2, 2);
    mem[8'h06] = i3(OP_ST, 4, 6, 0); mem[8'h07] = li(1, 8'h02);
    mem[8'h08] = li(2, 8'h05);       mem[8'h09] = i3(OP_SUB, 3, 1, 2);
    mem[8'h0A] = i3(OP_ST, 3, 6, 0); mem[8'h0B] = i3(OP_AND, 3, 1, 2);
    mem[8'h0C] = i3(OP_ST, 3, 6, 0); mem[8'h0D] = i3(OP_OR, 3, 1, 2);
    mem[8'h0E] = i3(OP_ST, 3, 6, 0); mem[8'h0F] = 16'hF000;

    repeat (3) @(posedge clk);
    #1 chk("rst_held_req", 32'(mif.mem_req), 32'd0);
    @(posedge clk);
    #2 Rst_n = 1'b1;
    #1;
    chk("rst_req",    32'(mif.mem_req), 32'd1);
    chk("rst_addr",   32'(mif.mem_addr), 32'h00);
    chk("rst_pc",     32'(pc), 32'h00);
    chk("rst_psw",    32'(psw), 32'h0);
    chk("rst_state",  32'(state), 32'(S_FETCH));
    chk("rst_halted", 32'(halted), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("fetch_wait_req",  32'(mif.mem_req), 32'd1);
    chk("fetch_wait_addr", 32'(mif.mem_addr), 32'h00);
    #2 Rst_n = 1'b0;
    #1;
    chk("midfetch_rst_req", 32'(mif.mem_req), 32'd0);

    stall = 1'b0;
    oi = obs.size();
    ex(0, 8'h00, 0, 0, 0);
    ex(0, 8'h01, 0, 0, 4);  ex(0, 8'h02, 0, 0, 4);  ex(0, 8'h03, 0, 0, 4);
    ex(0, 8'h04, 0, 0, 4);  ex(1, 8'h30, 16'h0000, 3'b011, 3);
    ex(0, 8'h05, 0, 0, 1);  ex(0, 8'h06, 0, 0, 4);  ex(1, 8'h30, 16'h0003, 3'b000, 3);
    ex(0, 8'h07, 0, 0, 1);  ex(0, 8'h08, 0, 0, 4);  ex(0, 8'h09, 0, 0, 4);
    ex(0, 8'h0A, 0, 0, 4);  ex(1, 8'h30, 16'hFFFD, 3'b100, 3);
    ex(0, 8'h0B, 0, 0, 1);  ex(0, 8'h0C, 0, 0, 4);  ex(1, 8'h30, 16'h0000, 3'b010, 3);
    ex(0, 8'h0D, 0, 0, 1);  ex(0, 8'h0E, 0, 0, 4);  ex(1, 8'h30, 16'h0007, 3'b000, 3);
    ex(0, 8'h0F, 0, 0, 1);
    @(posedge clk);
    #2 Rst_n = 1'b1;
    wait_halt_and_compare("A");
    chk("A_halt_pc",    32'(pc), 32'h10);
    chk("A_halt_state", 32'(state), 32'(S_HALT));
    chk("A_final_psw",  32'(psw), 32'h0);
    hreq = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (mif.mem_req !== 1'b0) hreq++;
    end
    chk("A_halt_no_req", 32'(hreq), 32'd0);
    chk("A_halt_pc_frozen", 32'(pc), 32'h10);

    // Program B: waited LD/ST, BZ taken/not taken, JMP, JAL
    @(posedge clk);
    #2 Rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = li(1, 8'h40);       mem[8'h01] = i3(OP_LD, 5, 1, 0);
    mem[8'h02] = i3(OP_ST, 5, 1, 0); mem[8'h03] = li(2, 8'h10);
    mem[8'h04] = i3(OP_SUB, 3, 2, 2); mem[8'h05] = i3(OP_JMP, 0, 2, 0);
    mem[8'h0F] = i3(OP_ADD, 3, 2, 2); mem[8'h10] = {OP_BZ, 4'h0, 8'hFE};
    mem[8'h11] = li(6, 8'h40);       mem[8'h12] = i3(OP_ADD, 6, 6, 6);
    mem[8'h13] = li(4, 8'h20);       mem[8'h14] = i3(OP_JMP, 0, 4, 0);
    mem[8'h20] = i3(OP_JAL, 7, 6, 0); mem[8'h80] = i3(OP_ST, 7, 0, 0);
    mem[8'h81] = 16'hF000;           mem[8'h40] = 16'h1234;
    ex(0, 8'h00, 0, 0, 0);
    ex(0, 8'h01, 0, 0, 4);  ex(0, 8'h40, 0, 0, 6);  ex(0, 8'h02, 0, 0, 2);
    ex(1, 8'h40, 16'h1234, 3'b000, 6);               ex(0, 8'h03, 0, 0, 1);
    ex(0, 8'h04, 0, 0, 4);  ex(0, 8'h05, 0, 0, 4);  ex(0, 8'h10, 0, 0, 3);
    ex(0, 8'h0F, 0, 0, 3);  ex(0, 8'h10, 0, 0, 4);  ex(0, 8'h11, 0, 0, 3);
    ex(0, 8'h12, 0, 0, 4);  ex(0, 8'h13, 0, 0, 4);  ex(0, 8'h14, 0, 0, 4);
    ex(0, 8'h20, 0, 0, 3);  ex(0, 8'h80, 0, 0, 4);
    ex(1, 8'h00, 16'h0021, 3'b000, 3);               ex(0, 8'h81, 0, 0, 1);
    #1 chk("B_rst_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #2 Rst_n = 1'b1;
    #1;
    chk("B_restart_req",  32'(mif.mem_req), 32'd1);
    chk("B_restart_addr", 32'(mif.mem_addr), 32'h00);
    wait_halt_and_compare("B");
    chk("B_halt_pc", 32'(pc), 32'h82);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
